// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM state and mode encodings for the LFSR stream generator
package lfsr_pkg;
  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;
  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational Fibonacci/Galois LFSR step
//   i_q      current state          i_tap    feedback mask (bit 0 implicit)
//   i_mode   MODE_FIB / MODE_GAL    o_q_next state after one step
//   o_bit    generated bit (i_q[0])
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int NBITS = 16
) (
  input  logic [NBITS-1:0] i_q,
  input  logic [NBITS-1:0] i_tap,
  input  logic             i_mode,
  output logic [NBITS-1:0] o_q_next,
  output logic             o_bit
);
  logic             w_fb;
  logic [NBITS-1:0] w_fib;
  logic [NBITS-1:0] w_gal;
  // tap[0] is forced on so q[0] always enters the feedback
  assign w_fb     = ^((i_tap | NBITS'(1)) & i_q);
  assign w_fib    = {w_fb, i_q[NBITS-1:1]};
  assign w_gal    = {i_q[0], i_q[NBITS-1:1] ^ (i_tap[NBITS-1:1] & {(NBITS-1){i_q[0]}})};
  assign o_q_next = (i_mode == MODE_GAL) ? w_gal : w_fib;
  assign o_bit    = i_q[0];
endmodule

// File: rtl/lfsr_stream.sv
// lfsr_stream: LFSR bit generator packing OUT_W-bit words onto a valid/ready stream
//   clk, rst (async, active-low)
//   en        run enable          load/seed  synchronous seed load
//   tap/mode  feedback mask and Fibonacci/Galois select
//   out_data/out_valid/out_ready  output word stream (LSB = first bit)
//   busy      FSM not idle        lockup     one-cycle all-zero recovery pulse
//   Define LFSR_STREAM_LOCKUP_EN to enable all-zero state recovery.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int              NBITS      = 16,
  parameter int              OUT_W      = 8,
  parameter logic [NBITS-1:0] RESET_SEED = 'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [NBITS-1:0] seed,
  input  logic [NBITS-1:0] tap,
  input  logic             mode,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             lockup
);
  localparam int CW = $clog2(OUT_W + 1);
`ifdef LFSR_STREAM_LOCKUP_EN
  localparam bit LOCKUP_EN = 1'b1;
`else
  localparam bit LOCKUP_EN = 1'b0;
`endif
  state_t           r_state, w_state;
  logic [NBITS-1:0] r_q, w_q, w_step_q;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [OUT_W-1:0] r_word, w_word;
  logic             r_valid, w_valid;
  logic             r_lockup, w_lockup;
  logic             w_bit;
  lfsr_step #(.NBITS(NBITS)) u_step (
    .i_q      (r_q),
    .i_tap    (tap),
    .i_mode   (mode),
    .o_q_next (w_step_q),
    .o_bit    (w_bit)
  );
  always_comb begin
    w_state  = r_state;
    w_q      = r_q;
    w_cnt    = r_cnt;
    w_word   = r_word;
    w_valid  = r_valid;
    w_lockup = 1'b0;
    if (load) begin
      w_state = IDLE;
      w_q     = seed;
      w_cnt   = '0;
      w_valid = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (en) begin
          w_state = GEN;
          w_cnt   = '0;
        end
        GEN: if (en) begin
          if (LOCKUP_EN && r_q == '0) begin
            w_q      = RESET_SEED;
            w_lockup = 1'b1;
          end else begin
            // right-shifting in at the MSB leaves the first bit at the LSB once OUT_W bits are in
            w_q    = w_step_q;
            w_word = OUT_W'({w_bit, r_word} >> 1);
            w_cnt  = r_cnt + 1'b1;
            if (r_cnt == CW'(OUT_W - 1)) begin
              w_state = HOLD;
              w_valid = 1'b1;
            end
          end
        end
        HOLD: if (out_ready) begin
          w_valid = 1'b0;
          w_cnt   = '0;
          w_state = en ? GEN : IDLE;
        end
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_q      <= RESET_SEED;
      r_cnt    <= '0;
      r_word   <= '0;
      r_valid  <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_q      <= w_q;
      r_cnt    <= w_cnt;
      r_word   <= w_word;
      r_valid  <= w_valid;
      r_lockup <= w_lockup;
    end
  end
  assign out_data  = r_word;
  assign out_valid = r_valid;
  assign busy      = (r_state != IDLE);
  assign lockup    = r_lockup;
endmodule

// File: tb/tb_lfsr_stream.sv
// tb_lfsr_stream: scoreboard bench for lfsr_stream (NBITS=4, OUT_W=8, tap x^4+x+1)
module tb_lfsr_stream;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       mode = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] seed = 4'h0;
  logic [3:0] tap = 4'b0011;
  logic [7:0] out_data;
  logic       out_valid, busy, lockup;
  int         checks = 0;
  int         errors = 0;
  int         lock_cnt = 0;
  int         n;
  int         base;
  logic [7:0] sb[$];
  logic [7:0] exp_w;

  lfsr_stream #(.NBITS(4), .OUT_W(8), .RESET_SEED(4'h1)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .seed      (seed),
    .tap       (tap),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .lockup    (lockup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (lockup) lock_cnt++;
    if (rst && out_valid && out_ready && !load) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        exp_w = sb.pop_front();
        chk("word", out_data, exp_w);
      end
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!out_valid && cnt < 50);
    chk(name, out_valid, 1);
  endtask

  task automatic do_load(input logic [3:0] s, input logic m);
    en = 1'b0;
    load = 1'b1;
    seed = s;
    mode = m;
    tick();
    load = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (!(out_valid && sb.size() == 1) && k < 100) begin
      tick();
      k++;
    end
    chk({name, "_last_valid"}, out_valid, 1);
    en = 1'b0;
    tick();
    chk({name, "_sb_empty"}, sb.size(), 0);
    chk({name, "_idle"}, {busy, out_valid}, 2'b00);
  endtask

  initial begin
    tick(2);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lockup", lockup, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    // Fibonacci: latency, throughput and a full period across four words
    do_load(4'h1, 1'b0);
    sb.push_back(8'h91);
    sb.push_back(8'hF5);
    sb.push_back(8'hC8);
    sb.push_back(8'h7A);
    en = 1'b1;
    out_ready = 1'b1;
    wait_valid("lat_valid", n);
    chk("latency", n, 9);
    wait_valid("thr_valid", n);
    chk("throughput", n, 9);
    drain("fib");
    // Galois with the same tap
    do_load(4'h1, 1'b1);
    sb.push_back(8'hAF);
    sb.push_back(8'h89);
    en = 1'b1;
    drain("gal");
    // back-pressure in HOLD
    do_load(4'h1, 1'b0);
    out_ready = 1'b0;
    sb.push_back(8'h91);
    sb.push_back(8'hF5);
    en = 1'b1;
    wait_valid("hold_valid", n);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid_stays", out_valid, 1);
      chk("hold_data_stable", out_data, 8'h91);
    end
    out_ready = 1'b1;
    drain("hold");
    // pause mid-word at cnt=3
    do_load(4'h1, 1'b0);
    sb.push_back(8'h91);
    en = 1'b1;
    tick(4);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_valid", out_valid, 0);
      chk("pause_busy", busy, 1);
    end
    en = 1'b1;
    drain("pause");
    // load during HOLD with a same-cycle handshake discards the word
    do_load(4'h1, 1'b0);
    out_ready = 1'b0;
    en = 1'b1;
    wait_valid("disc_hold", n);
    load = 1'b1;
    seed = 4'hA;
    out_ready = 1'b1;
    tick();
    load = 1'b0;
    chk("disc_valid_fall", out_valid, 0);
    chk("disc_busy", busy, 0);
    sb.push_back(8'h7A);
    drain("disc");
    // zero seed
    base = lock_cnt;
    do_load(4'h0, 1'b0);
`ifdef LFSR_STREAM_LOCKUP_EN
    sb.push_back(8'h91);
`else
    sb.push_back(8'h00);
`endif
    en = 1'b1;
    drain("zero");
`ifdef LFSR_STREAM_LOCKUP_EN
    chk("lockup_pulses", lock_cnt - base, 1);
`else
    chk("lockup_pulses", lock_cnt - base, 0);
`endif
    // asynchronous reset mid-word
    do_load(4'h1, 1'b0);
    en = 1'b1;
    tick(4);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_lockup", lockup, 0);
    chk("arst_data", out_data, 0);
    en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
